// File: rtl/pc_fetch_if.sv
// Instruction-byte memory bus between the fetch unit (master) and instruction memory (slave).
interface pc_fetch_if;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/pc_fetch.sv
// Y86-64 style byte-serial instruction fetch: reads opcode, register and constant bytes.
// Optional memory timeout enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] newPC,
   pc_fetch_if.master  mem,
   output logic [63:0] PC,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic        instr_valid,
   output logic        instr_invalid,
   output logic        imem_error,
   output logic        busy,
   output logic        halted
);
   typedef enum logic [2:0] {IDLE, BYTE0, REGS, CONST, DONE, HALTED} state_t;

   state_t      state;
   logic [2:0]  cidx;
   logic [3:0]  b0_icode;
   logic [3:0]  cur_icode;
   logic        ack;
   logic        last;
   logic        launch;
   logic        halt_ic;
   logic        timeout;

   function automatic logic has_regs(input logic [3:0] ic);
      return ic inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11};
   endfunction

   function automatic logic has_const(input logic [3:0] ic);
      return ic inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
   endfunction

   function automatic logic [3:0] ilen(input logic [3:0] ic);
      return 4'd1 + {3'd0, has_regs(ic)} + {has_const(ic), 3'b000};
   endfunction

   assign ack       = mem.mem_req & mem.mem_ack;
   assign b0_icode  = mem.mem_rdata[7:4];
   assign cur_icode = (state == BYTE0) ? b0_icode : icode;
   assign halt_ic   = (icode == 4'd0) || (icode > 4'd11);
   assign launch    = start && ((state == IDLE) || ((state == DONE) && !halt_ic));

   // Final byte of the instruction, judged from the icode known in the current state
   always_comb begin
      last = 1'b0;
      case (state)
         BYTE0:   last = !has_regs(b0_icode) && !has_const(b0_icode);
         REGS:    last = !has_const(icode);
         CONST:   last = (cidx == 3'd7);
         default: last = 1'b0;
      endcase
   end

`ifdef FETCH_TIMEOUT_EN
   logic [3:0] tcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt       <= '0;
         imem_error <= 1'b0;
      end else if (!mem.mem_req || mem.mem_ack) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 4'd1;
         if (tcnt == 4'd14) imem_error <= 1'b1;
      end
   end

   assign timeout = mem.mem_req && !mem.mem_ack && (tcnt == 4'd14);
`else
   assign timeout    = 1'b0;
   assign imem_error = 1'b0;
`endif

   // Later assignments below override the per-state update: final ack, launch, timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         PC            <= '0;
         valC          <= '0;
         valP          <= '0;
         icode         <= '0;
         ifun          <= '0;
         rA            <= '1;
         rB            <= '1;
         cidx          <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_addr  <= '0;
         instr_valid   <= 1'b0;
         instr_invalid <= 1'b0;
         halted        <= 1'b0;
         busy          <= 1'b0;
      end else begin
         instr_valid   <= 1'b0;
         instr_invalid <= 1'b0;
         case (state)
            BYTE0: if (ack) begin
               icode        <= mem.mem_rdata[7:4];
               ifun         <= mem.mem_rdata[3:0];
               rA           <= '1;
               rB           <= '1;
               valC         <= '0;
               valP         <= PC + {60'd0, ilen(b0_icode)};
               cidx         <= '0;
               mem.mem_addr <= mem.mem_addr + 64'd1;
               state        <= has_regs(b0_icode) ? REGS : CONST;
            end
            REGS: if (ack) begin
               rA           <= mem.mem_rdata[7:4];
               rB           <= mem.mem_rdata[3:0];
               mem.mem_addr <= mem.mem_addr + 64'd1;
               state        <= CONST;
            end
            CONST: if (ack) begin
               valC[{cidx, 3'b000} +: 8] <= mem.mem_rdata;
               cidx         <= cidx + 3'd1;
               mem.mem_addr <= mem.mem_addr + 64'd1;
            end
            DONE: begin
               busy <= 1'b0;
               if (halt_ic) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: ;
         endcase

         if (ack && last) begin
            state         <= DONE;
            mem.mem_req   <= 1'b0;
            instr_valid   <= 1'b1;
            instr_invalid <= (cur_icode > 4'd11);
         end

         if (launch) begin
            state        <= BYTE0;
            PC           <= newPC;
            mem.mem_addr <= newPC;
            mem.mem_req  <= 1'b1;
            busy         <= 1'b1;
         end

         if (timeout) begin
            state       <= HALTED;
            mem.mem_req <= 1'b0;
            halted      <= 1'b1;
            busy        <= 1'b0;
         end
      end
   end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: start  in  1  strobe; begin fetch at newPC.
REQ-004 SHALL: newPC  in  64  next-instruction address from PC-update stage.
REQ-005 SHALL: mem_req  out  1  instruction-byte read request.
REQ-006 SHALL: mem_addr  out  64  byte address of the current request.
REQ-007 SHALL: mem_ack  in  1  byte returned this cycle on mem_rdata.
REQ-008 SHALL: mem_rdata  in  8  instruction byte.
REQ-009 SHALL: PC  out  64  address of the instruction being or last fetched.
REQ-010 SHALL: icode, ifun, rA, rB  out  4 each  decoded fields.
REQ-011 SHALL: valC  out  64  constant word; valP  out  64  PC plus instruction length.
REQ-012 SHALL: instr_valid  out  1  one-cycle pulse; all decoded fields valid.
REQ-013 SHALL: instr_invalid  out  1  pulse alongside instr_valid when icode exceeds 11.
REQ-014 SHALL: imem_error  out  1  sticky; memory timeout.
REQ-015 SHALL: busy  out  1  high in any state except IDLE and HALTED; halted  out  1  sticky.

Function
REQ-016 SHALL: FSM states are IDLE, BYTE0, REGS, CONST, DONE, HALTED.
REQ-017 SHALL: in IDLE or DONE, start=1 latches newPC into PC and enters BYTE0; start SHALL be ignored in every other state.
REQ-018 SHALL: mem_req is high only in BYTE0, REGS and CONST; mem_addr = PC + byte index (mod 2^64); both are held stable until mem_ack.
REQ-019 SHALL: a byte is consumed only in a cycle where mem_req and mem_ack are both 1; mem_ack without mem_req is ignored.
REQ-020 SHALL: byte 0 gives icode=[7:4] and ifun=[3:0]; instruction length is then fixed from icode.
REQ-021 SHALL: lengths are 1 for icode 0, 1, 9 and any icode >11; 2 for 2, 6, 10, 11; 9 for 7, 8; 10 for 3, 4, 5.
REQ-022 SHALL: the REGS byte gives rA=[7:4] and rB=[3:0]; with no REGS byte, rA=rB=4'hF.
REQ-023 SHALL: CONST captures 8 bytes little-endian (first byte to valC[7:0]); with no constant, valC=0.
REQ-024 SHALL: valP = PC + length, 64-bit wrap-around.
REQ-025 SHALL: the cycle after the final ack, the FSM enters DONE and instr_valid=1 for exactly one cycle.
REQ-026 SHALL: with zero-wait memory, instr_valid occurs length+1 cycles after the start cycle.
REQ-027 SHALL: icode 0 (halt) or an invalid icode moves DONE to HALTED instead of IDLE and sets halted; start is ignored until rst.
REQ-028 SHALL: outputs hold their values between fetches until the next byte-0 capture.

Reset
REQ-029 SHALL: rst dominates start and mem_ack in the same cycle.
REQ-030 SHALL: on rst, state=IDLE; PC, valC, valP=0; icode, ifun=0; rA, rB=4'hF; mem_req, instr_valid, instr_invalid, imem_error, halted, busy=0.
REQ-031 SHALL: rst mid-fetch aborts the fetch with no instr_valid and drops mem_req the following cycle.

Configuration
REQ-032 SHALL: with FETCH_TIMEOUT_EN defined, a 4-bit counter counts cycles with mem_req=1 and mem_ack=0.
REQ-033 SHALL: under FETCH_TIMEOUT_EN, the counter clears on every ack; on reaching 15, it sets imem_error, drops mem_req and enters HALTED with halted=1.
REQ-034 SHALL: without FETCH_TIMEOUT_EN, the block waits indefinitely for mem_ack and imem_error is constant 0.

Verification
REQ-035 SHALL: after rst, start with newPC=0x100, zero-wait memory, bytes 30 F3 EF CD AB 89 67 45 23 01 -> instr_valid at cycle 11, icode=3, ifun=0, rA=F, rB=3, valC=0x0123456789ABCDEF, valP=0x10A.
REQ-036 SHALL: newPC=0x20, byte 90 -> instr_valid at cycle 2, icode=9, rA=rB=F, valC=0, valP=0x21, busy=0 afterwards.
REQ-037 SHALL: newPC=0xFFFFFFFFFFFFFFFF, bytes 60 12 -> mem_addr sequence FF..FF then 0x0, valP=0x1.
REQ-038 SHALL: byte 00 -> instr_valid pulse, halted=1; a subsequent start is ignored and mem_req stays 0 until rst.
REQ-039 SHALL: byte C0 -> instr_valid and instr_invalid pulse together, halted=1; under FETCH_TIMEOUT_EN, mem_ack held low for 15 cycles -> imem_error=1; rst asserted at byte 4 of irmovq -> no instr_valid, state IDLE.
